// File: rtl/axi_bridge_pkg.sv
// Shared types and constants for the single-outstanding AXI4 bridge.
// Holds the FSM state encoding and the fixed single-beat burst attributes.
package axi_bridge_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned STRB_W     = 4;
  localparam int unsigned STALL_W    = 6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_D_AR = 3'd1,
    ST_D_R  = 3'd2,
    ST_D_AW = 3'd3,
    ST_D_B  = 3'd4,
    ST_I_AR = 3'd5,
    ST_I_R  = 3'd6,
    ST_RESP = 3'd7
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [7:0] LEN_1      = 8'd0;
  localparam logic [3:0] ID_0       = 4'd0;

endpackage

// File: rtl/axi_bridge.sv
// Single-outstanding AXI4 master serving the core's SRAM-style fetch and
// load/store ports; the data access is always completed before the fetch.
module axi_bridge
  import axi_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_en,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_en,
  input  logic [STRB_W-1:0] data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              stallreq_axi,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [3:0]        arid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic [3:0]        awid,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  state_e state;
  logic   aw_done;
  logic   w_done;
  logic   aw_hs;
  logic   w_hs;
  logic   unused_resp;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  // Error responses carry no exception path; data is passed through as-is.
  assign unused_resp = ^{rresp, bresp};

  assign arlen   = LEN_1;
  assign arsize  = SIZE_4B;
  assign arburst = BURST_INCR;
  assign arid    = ID_0;
  assign awlen   = LEN_1;
  assign awsize  = SIZE_4B;
  assign awburst = BURST_INCR;
  assign awid    = ID_0;

  // Freeze from the first cycle a request is seen until the RESP cycle.
  assign stallreq_axi = ((state == ST_IDLE) && (inst_en || data_en)) ||
                        ((state != ST_IDLE) && (state != ST_RESP));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      arvalid    <= 1'b0;
      araddr     <= '0;
      rready     <= 1'b0;
      awvalid    <= 1'b0;
      awaddr     <= '0;
      wvalid     <= 1'b0;
      wdata      <= '0;
      wstrb      <= '0;
      bready     <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      inst_rdata <= '0;
      data_rdata <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (data_en && (data_we == '0)) begin
            state   <= ST_D_AR;
            arvalid <= 1'b1;
            araddr  <= data_addr;
          end else if (data_en) begin
            state   <= ST_D_AW;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            awaddr  <= data_addr;
            wdata   <= data_wdata;
            wstrb   <= data_we;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else if (inst_en) begin
            state   <= ST_I_AR;
            arvalid <= 1'b1;
            araddr  <= inst_addr;
          end
        end
        ST_D_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= ST_D_R;
          end
        end
        ST_D_R: begin
          if (rvalid) begin
            data_rdata <= rdata;
            rready     <= 1'b0;
            if (inst_en) begin
              state   <= ST_I_AR;
              arvalid <= 1'b1;
              araddr  <= inst_addr;
            end else begin
              state <= ST_RESP;
            end
          end
        end
        // AW and W retire independently; leave once both have handshaken.
        ST_D_AW: begin
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            state  <= ST_D_B;
            bready <= 1'b1;
          end
        end
        ST_D_B: begin
          if (bvalid) begin
            bready <= 1'b0;
            if (inst_en) begin
              state   <= ST_I_AR;
              arvalid <= 1'b1;
              araddr  <= inst_addr;
            end else begin
              state <= ST_RESP;
            end
          end
        end
        ST_I_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= ST_I_R;
          end
        end
        ST_I_R: begin
          if (rvalid) begin
            inst_rdata <= rdata;
            rready     <= 1'b0;
            state      <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_bridge.sv
// Self-checking bench for axi_bridge: a delay-programmable AXI slave, a
// handshake monitor, directed vectors and a transaction-level random model.
module tb_axi_bridge;
  import axi_bridge_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        inst_en;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        data_en;
  logic [3:0]  data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        stallreq_axi;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic [3:0]  arid, awid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int checks = 0;
  int errors = 0;

  axi_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .data_en(data_en), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata),
    .stallreq_axi(stallreq_axi),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .arlen(arlen), .arsize(arsize), .arburst(arburst), .arid(arid),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .awlen(awlen), .awsize(awsize), .awburst(awburst), .awid(awid),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Slave memory contents
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 32'h0000_0013;
      32'h0000_1004: return 32'h00A0_0093;
      32'h0000_2004: return 32'hDEAD_BEEF;
      32'h0000_3000: return 32'h1234_5678;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  // Slave: each ready/valid answers after a programmable number of wait cycles
  int ar_d, r_d, aw_d, w_d, b_d;
  logic [1:0] cfg_rresp;
  int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  int aw_hs_n, w_hs_n, b_hs_n;
  logic [31:0] r_addr;
  logic [31:0] ar_log[$];
  logic [31:0] aw_log[$];
  logic [35:0] w_log[$];

  assign arready = arvalid && (ar_cnt == ar_d);
  assign rvalid  = rready && (r_cnt == r_d);
  assign rdata   = rvalid ? mem_word(r_addr) : 32'hBAD0_BAD0;
  assign rresp   = cfg_rresp;
  assign awready = awvalid && (aw_cnt == aw_d);
  assign wready  = wvalid && (w_cnt == w_d);
  assign bvalid  = bready && (b_cnt == b_d);
  assign bresp   = 2'b00;

  always @(posedge clk) begin
    ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
    r_cnt  <= (rready && !rvalid) ? r_cnt + 1 : 0;
    aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
    w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
    b_cnt  <= (bready && !bvalid) ? b_cnt + 1 : 0;
    if (!rst_n) begin
      aw_hs_n <= 0;
      w_hs_n  <= 0;
      b_hs_n  <= 0;
    end else begin
      if (arvalid && arready) begin
        r_addr <= araddr;
        ar_log.push_back(araddr);
      end
      if (awvalid && awready) begin
        aw_log.push_back(awaddr);
        aw_hs_n <= aw_hs_n + 1;
      end
      if (wvalid && wready) begin
        w_log.push_back({wstrb, wdata});
        w_hs_n <= w_hs_n + 1;
      end
      if (bvalid && bready) b_hs_n <= b_hs_n + 1;
    end
  end

  // Handshake monitor: stalled valids hold their payload, B and AR ordering
  logic        pend_ar, pend_aw, pend_w;
  logic [31:0] pend_araddr, pend_awaddr;
  logic [35:0] pend_wval;
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_ar = 1'b0;
      pend_aw = 1'b0;
      pend_w  = 1'b0;
    end else begin
      if (pend_ar) chk("ar_hold", 64'({arvalid, araddr}), 64'({1'b1, pend_araddr}));
      if (pend_aw) chk("aw_hold", 64'({awvalid, awaddr}), 64'({1'b1, pend_awaddr}));
      if (pend_w)  chk("w_hold", 64'({wvalid, wstrb, wdata}), 64'({1'b1, pend_wval}));
      if (bready)
        chk("bready_after_aw_w", 64'({aw_hs_n == w_hs_n, aw_hs_n == b_hs_n + 1}), 64'(2'b11));
      if (arvalid) chk("ar_no_open_write", 64'(b_hs_n), 64'(aw_hs_n));
      pend_ar     = arvalid && !arready;
      pend_araddr = araddr;
      pend_aw     = awvalid && !awready;
      pend_awaddr = awaddr;
      pend_w      = wvalid && !wready;
      pend_wval   = {wstrb, wdata};
    end
  end

  typedef struct {
    logic        ien;
    logic [31:0] iaddr;
    logic        den;
    logic [3:0]  we;
    logic [31:0] daddr;
    logic [31:0] wdata;
    int          ar_d, r_d, aw_d, w_d, b_d;
    logic [1:0]  rresp;
    int          exp_stall;
    logic [31:0] exp_inst;
    logic [31:0] exp_data;
  } vec_t;

  function automatic vec_t mk(input logic ien, input logic [31:0] iaddr, input logic den,
                              input logic [3:0] we, input logic [31:0] daddr, input logic [31:0] wd,
                              input int ard, input int rd, input int awd, input int wdd, input int bd,
                              input logic [1:0] rr, input int est, input logic [31:0] ei,
                              input logic [31:0] ed);
    vec_t v;
    v.ien = ien; v.iaddr = iaddr; v.den = den; v.we = we; v.daddr = daddr; v.wdata = wd;
    v.ar_d = ard; v.r_d = rd; v.aw_d = awd; v.w_d = wdd; v.b_d = bd; v.rresp = rr;
    v.exp_stall = est; v.exp_inst = ei; v.exp_data = ed;
    return v;
  endfunction

  // Reference model: last values the core has seen, and cycle cost per phase
  logic [31:0] m_inst, m_data;

  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int st = 1;
    if (v.den && v.we == 4'd0) st += (v.ar_d + 1) + (v.r_d + 1);
    if (v.den && v.we != 4'd0) st += ((v.aw_d > v.w_d ? v.aw_d : v.w_d) + 1) + (v.b_d + 1);
    if (v.ien) st += (v.ar_d + 1) + (v.r_d + 1);
    r.exp_stall = st;
    r.exp_inst  = v.ien ? mem_word(v.iaddr) : m_inst;
    r.exp_data  = (v.den && v.we == 4'd0) ? mem_word(v.daddr) : m_data;
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int stall;
    logic [31:0] exp_ar[$];
    ar_d = v.ar_d; r_d = v.r_d; aw_d = v.aw_d; w_d = v.w_d; b_d = v.b_d;
    cfg_rresp = v.rresp;
    ar_log.delete(); aw_log.delete(); w_log.delete();
    @(negedge clk);
    inst_en = v.ien; inst_addr = v.iaddr;
    data_en = v.den; data_we = v.we; data_addr = v.daddr; data_wdata = v.wdata;
    #1;
    stall = 0;
    while (stallreq_axi && stall < 200) begin
      stall++;
      @(negedge clk);
      #1;
    end
    chk({tag, "_stall_cycles"}, 64'(stall), 64'(v.exp_stall));
    chk({tag, "_resp_inst"}, 64'(inst_rdata), 64'(v.exp_inst));
    chk({tag, "_resp_data"}, 64'(data_rdata), 64'(v.exp_data));
    inst_en = 1'b0;
    data_en = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, "_idle_hold"}, 64'({stallreq_axi, arvalid, awvalid, wvalid, rready, bready, inst_rdata, data_rdata}),
        64'({6'b0, v.exp_inst, v.exp_data}));
    if (v.den && v.we == 4'd0) exp_ar.push_back(v.daddr);
    if (v.ien) exp_ar.push_back(v.iaddr);
    chk({tag, "_ar_count"}, 64'(ar_log.size()), 64'(exp_ar.size()));
    for (int i = 0; i < exp_ar.size() && i < ar_log.size(); i++)
      chk($sformatf("%s_ar%0d_addr", tag, i), 64'(ar_log[i]), 64'(exp_ar[i]));
    if (v.den && v.we != 4'd0) begin
      chk({tag, "_aw_w_count"}, 64'({aw_log.size(), w_log.size()}), {32'd1, 32'd1});
      if (aw_log.size() == 1) chk({tag, "_awaddr"}, 64'(aw_log[0]), 64'(v.daddr));
      if (w_log.size() == 1) chk({tag, "_wstrb_wdata"}, 64'(w_log[0]), 64'({v.we, v.wdata}));
    end else begin
      chk({tag, "_no_write"}, 64'({aw_log.size(), w_log.size()}), 64'(0));
    end
    m_inst = v.exp_inst;
    m_data = v.exp_data;
  endtask

  vec_t vecs[8];

  initial begin
    rst_n = 1'b0; inst_en = 1'b0; inst_addr = '0; data_en = 1'b0; data_we = '0;
    data_addr = '0; data_wdata = '0;
    ar_d = 0; r_d = 0; aw_d = 0; w_d = 0; b_d = 0; cfg_rresp = 2'b00;
    m_inst = '0; m_data = '0;

    vecs[0] = mk(1, 32'h1000, 0, 4'h0, 32'h0,    32'h0,        0, 0, 0, 0, 0, 2'b00, 3,  32'h0000_0013, 32'h0);
    vecs[1] = mk(1, 32'h1004, 1, 4'h0, 32'h2004, 32'h0,        0, 0, 0, 0, 0, 2'b00, 5,  32'h00A0_0093, 32'hDEAD_BEEF);
    vecs[2] = mk(1, 32'h1000, 1, 4'h3, 32'h2008, 32'h0000_BEEF, 0, 0, 3, 0, 1, 2'b00, 9,  32'h0000_0013, 32'hDEAD_BEEF);
    vecs[3] = mk(1, 32'h1004, 0, 4'h0, 32'h0,    32'h0,        10, 0, 0, 0, 0, 2'b00, 13, 32'h00A0_0093, 32'hDEAD_BEEF);
    vecs[4] = mk(1, 32'h3000, 0, 4'h0, 32'h0,    32'h0,        0, 0, 0, 0, 0, 2'b10, 3,  32'h1234_5678, 32'hDEAD_BEEF);
    vecs[5] = mk(0, 32'h0,    1, 4'h0, 32'h1000, 32'h0,        1, 2, 0, 0, 0, 2'b00, 6,  32'h1234_5678, 32'h0000_0013);
    vecs[6] = mk(0, 32'h0,    1, 4'hF, 32'h2010, 32'hCAFE_F00D, 0, 0, 0, 2, 0, 2'b00, 5,  32'h1234_5678, 32'h0000_0013);
    vecs[7] = mk(1, 32'h1000, 1, 4'h0, 32'h3000, 32'h0,        0, 1, 0, 0, 0, 2'b11, 7,  32'h0000_0013, 32'h1234_5678);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 64'({arvalid, rready, awvalid, wvalid, bready, stallreq_axi, araddr}), 64'(0));
    chk("reset_rdata", 64'({inst_rdata, data_rdata}), 64'(0));
    chk("reset_wr_payload", 64'({awaddr, wstrb, wdata[27:0]}), 64'(0));
    chk("axi_constants", 64'({arlen, arsize, arburst, arid, awlen, awsize, awburst, awid}),
        64'({8'd0, 3'd2, 2'b01, 4'd0, 8'd0, 3'd2, 2'b01, 4'd0}));
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while the fetch read data phase is open
    begin
      int n = 0;
      ar_d = 0; r_d = 6;
      @(negedge clk);
      inst_en = 1'b1; inst_addr = 32'h1008;
      while (!rready && n < 20) begin
        n++;
        @(negedge clk);
      end
      chk("rst_reach_read_phase", 64'(rready), 64'(1));
      rst_n = 1'b0;
      inst_en = 1'b0;
      @(negedge clk);
      chk("rst_mid_read_ctrl", 64'({arvalid, rready, awvalid, wvalid, bready, stallreq_axi}), 64'(0));
      chk("rst_mid_read_rdata", 64'({inst_rdata, data_rdata}), 64'(0));
      rst_n = 1'b1;
      m_inst = '0;
      m_data = '0;
    end
    run_vec(model(mk(1, 32'h1004, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0)), "post_rst");

    // Randomized transactions against the model
    for (int i = 0; i < 40; i++) begin
      vec_t v;
      int kind = int'($urandom_range(0, 4));
      logic store = (kind == 2) || (kind == 4);
      v.ien   = (kind == 0) || (kind == 3) || (kind == 4);
      v.den   = (kind != 0);
      v.we    = store ? 4'($urandom_range(1, 15)) : 4'd0;
      v.iaddr = 32'($urandom_range(0, 16383)) << 2;
      v.daddr = 32'($urandom_range(0, 16383)) << 2;
      v.wdata = 32'($urandom());
      v.ar_d  = int'($urandom_range(0, 3));
      v.r_d   = int'($urandom_range(0, 3));
      v.aw_d  = int'($urandom_range(0, 3));
      v.w_d   = int'($urandom_range(0, 3));
      v.b_d   = int'($urandom_range(0, 3));
      v.rresp = 2'($urandom_range(0, 3));
      run_vec(model(v), $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
